// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers results from two arithmetic and two load-store
// units in per-source FIFOs and drains them round-robin onto the register
// file's two write ports, with stall back-pressure and a sticky overflow flag.
module writeback_arbiter #(
  parameter int DEPTH       = 4,
  parameter int STALL_LEVEL = 3
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flushBack_i,
  input  logic [3:0]  resValid_i,
  input  logic [3:0]  resIsWb_i,
  input  logic [19:0] resWbAddr_i,
  input  logic [63:0] resData_i,
  output logic        regWrEnA_o,
  output logic [4:0]  regWrAddrA_o,
  output logic [15:0] regWrDataA_o,
  output logic        regWrEnB_o,
  output logic [4:0]  regWrAddrB_o,
  output logic [15:0] regWrDataB_o,
  output logic        stall_o,
  output logic        overflow_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NSRC = 4;

  logic [4:0]      mem_addr   [NSRC][DEPTH];
  logic [15:0]     mem_data   [NSRC][DEPTH];
  logic [PW-1:0]   rd_ptr     [NSRC];
  logic [PW-1:0]   wr_ptr     [NSRC];
  logic [CW-1:0]   count      [NSRC];
  logic [CW-1:0]   count_next [NSRC];
  logic [4:0]      head_addr  [NSRC];
  logic [15:0]     head_data  [NSRC];
  logic [1:0]      rr_ptr;
  logic [1:0]      rr_next;

  logic [NSRC-1:0] push;
  logic [NSRC-1:0] deq;
  logic [NSRC-1:0] full;
  logic [NSRC-1:0] accept;
  logic [NSRC-1:0] drop;

  logic            a_vld;
  logic [1:0]      a_src;
  logic            b_found;
  logic            b_vld;
  logic [1:0]      b_src;
  logic [1:0]      scan_src;
  logic            stall_next;

  // FIFO head entries presented to the arbiter
  always_comb begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      head_addr[s] = mem_addr[s][rd_ptr[s]];
      head_data[s] = mem_data[s][rd_ptr[s]];
    end
  end

  // Round-robin scan from rr_ptr: first non-empty source to port A, next to
  // port B unless B would write the same register as A this cycle
  always_comb begin
    a_vld    = 1'b0;
    a_src    = '0;
    b_found  = 1'b0;
    b_src    = '0;
    b_vld    = 1'b0;
    scan_src = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      scan_src = rr_ptr + 2'(k);
      if (count[scan_src] != '0) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_src = scan_src;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_src   = scan_src;
        end
      end
    end
    b_vld = b_found && (head_addr[b_src] != head_addr[a_src]);
  end

  // Per-source enqueue/dequeue decisions, next occupancy, stall and pointer
  always_comb begin
    push       = '0;
    deq        = '0;
    full       = '0;
    accept     = '0;
    drop       = '0;
    stall_next = 1'b0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      push[s]   = resValid_i[s] & resIsWb_i[s];
      deq[s]    = (a_vld && (a_src == 2'(s))) || (b_vld && (b_src == 2'(s)));
      full[s]   = (count[s] == CW'(DEPTH));
      // a full FIFO that is also draining this edge still has room
      accept[s] = push[s] && (!full[s] || deq[s]);
      drop[s]   = push[s] && full[s] && !deq[s];
      count_next[s] = count[s] + CW'(accept[s]) - CW'(deq[s]);
      if (count_next[s] >= CW'(STALL_LEVEL)) begin
        stall_next = 1'b1;
      end
    end
    if (b_vld) begin
      rr_next = b_src + 2'd1;
    end else if (a_vld) begin
      rr_next = a_src + 2'd1;
    end else begin
      rr_next = rr_ptr;
    end
  end

  // FIFO storage writes (contents need no reset; occupancy gates visibility)
  always_ff @(posedge clock_i) begin
    if (!reset_i && !flushBack_i) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (accept[s]) begin
          mem_addr[s][wr_ptr[s]] <= resWbAddr_i[5*s +: 5];
          mem_data[s][wr_ptr[s]] <= resData_i[16*s +: 16];
        end
      end
    end
  end

  // FIFO pointers, arbitration pointer and registered outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        count[s]  <= '0;
      end
      rr_ptr       <= '0;
      regWrEnA_o   <= 1'b0;
      regWrAddrA_o <= '0;
      regWrDataA_o <= '0;
      regWrEnB_o   <= 1'b0;
      regWrAddrB_o <= '0;
      regWrDataB_o <= '0;
      stall_o      <= 1'b0;
      overflow_o   <= 1'b0;
    end else if (flushBack_i) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        count[s]  <= '0;
      end
      rr_ptr     <= '0;
      regWrEnA_o <= 1'b0;
      regWrEnB_o <= 1'b0;
      stall_o    <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (deq[s]) begin
          rd_ptr[s] <= rd_ptr[s] + PW'(1);
        end
        if (accept[s]) begin
          wr_ptr[s] <= wr_ptr[s] + PW'(1);
        end
        count[s] <= count_next[s];
      end
      rr_ptr     <= rr_next;
      regWrEnA_o <= a_vld;
      if (a_vld) begin
        regWrAddrA_o <= head_addr[a_src];
        regWrDataA_o <= head_data[a_src];
      end
      regWrEnB_o <= b_vld;
      if (b_vld) begin
        regWrAddrB_o <= head_addr[b_src];
        regWrDataB_o <= head_data[b_src];
      end
      stall_o <= stall_next;
      if (|drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: each step drives one cycle of inputs,
// a queue-based behavioural model predicts the registered outputs, the
// prediction is queued and then compared after the clock edge.
module tb_writeback_arbiter;

  localparam int DEPTH       = 4;
  localparam int STALL_LEVEL = 3;

  logic        clk;
  logic        reset_i;
  logic        flush;
  logic [3:0]  valid;
  logic [3:0]  iswb;
  logic [19:0] wb_addr;
  logic [63:0] wb_data;
  logic        en_a;
  logic [4:0]  addr_a;
  logic [15:0] data_a;
  logic        en_b;
  logic [4:0]  addr_b;
  logic [15:0] data_b;
  logic        stall;
  logic        overflow;

  writeback_arbiter #(.DEPTH(DEPTH), .STALL_LEVEL(STALL_LEVEL)) dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .flushBack_i  (flush),
    .resValid_i   (valid),
    .resIsWb_i    (iswb),
    .resWbAddr_i  (wb_addr),
    .resData_i    (wb_data),
    .regWrEnA_o   (en_a),
    .regWrAddrA_o (addr_a),
    .regWrDataA_o (data_a),
    .regWrEnB_o   (en_b),
    .regWrAddrB_o (addr_b),
    .regWrDataB_o (data_b),
    .stall_o      (stall),
    .overflow_o   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en_a;
    logic [4:0]  addr_a;
    logic [15:0] data_a;
    logic        en_b;
    logic [4:0]  addr_b;
    logic [15:0] data_b;
    logic        stall;
    logic        ovf;
  } exp_t;

  exp_t        exp_q [$];
  logic [20:0] mq [4][$];
  int          m_rr;
  exp_t        m;
  int          n_err;
  int          n_chk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Behavioural prediction of one clock edge
  task automatic model_edge(input logic rst, input logic fl, input logic [3:0] v,
                            input logic [3:0] wb, input logic [19:0] a, input logic [63:0] d);
    int ga, gb, last, s;
    logic [20:0] ha, hb;
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_rr = 0;
      m    = '0;
    end else if (fl) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_rr    = 0;
      m.en_a  = 1'b0;
      m.en_b  = 1'b0;
      m.stall = 1'b0;
    end else begin
      ga = -1;
      gb = -1;
      for (int k = 0; k < 4; k++) begin
        s = (m_rr + k) % 4;
        if (mq[s].size() > 0) begin
          if (ga < 0) ga = s;
          else if (gb < 0) gb = s;
        end
      end
      if (gb >= 0) begin
        ha = mq[ga][0];
        hb = mq[gb][0];
        if (ha[20:16] == hb[20:16]) gb = -1;
      end
      m.en_a = (ga >= 0);
      m.en_b = (gb >= 0);
      if (ga >= 0) {m.addr_a, m.data_a} = mq[ga].pop_front();
      if (gb >= 0) {m.addr_b, m.data_b} = mq[gb].pop_front();
      for (int i = 0; i < 4; i++) begin
        if (v[i] && wb[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back({a[5*i +: 5], d[16*i +: 16]});
          else m.ovf = 1'b1;
        end
      end
      last = (gb >= 0) ? gb : ga;
      if (last >= 0) m_rr = (last + 1) % 4;
      m.stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() >= STALL_LEVEL) m.stall = 1'b1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic fl, input logic [3:0] v,
                      input logic [3:0] wb, input logic [19:0] a, input logic [63:0] d);
    exp_t e;
    reset_i = rst;
    flush   = fl;
    valid   = v;
    iswb    = wb;
    wb_addr = a;
    wb_data = d;
    model_edge(rst, fl, v, wb, a, d);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("en_a",   16'(en_a),     16'(e.en_a));
    chk("addr_a", 16'(addr_a),   16'(e.addr_a));
    chk("data_a", data_a,        e.data_a);
    chk("en_b",   16'(en_b),     16'(e.en_b));
    chk("addr_b", 16'(addr_b),   16'(e.addr_b));
    chk("data_b", data_b,        e.data_b);
    chk("stall",  16'(stall),    16'(e.stall));
    chk("ovf",    16'(overflow), 16'(e.ovf));
    reset_i = 1'b0;
    flush   = 1'b0;
    valid   = '0;
    iswb    = '0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 4'h0, '0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'h0, 4'h0, '0, '0);
  endtask

  initial begin
    n_err   = 0;
    n_chk   = 0;
    m_rr    = 0;
    m       = '0;
    reset_i = 1'b1;
    flush   = 1'b0;
    valid   = '0;
    iswb    = '0;
    wb_addr = '0;
    wb_data = '0;

    // reset state
    do_reset();
    chk("rst_en_a", 16'(en_a), 16'd0);
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);

    // single arithA result, two-edge latency
    step(1'b0, 1'b0, 4'b0001, 4'b0001, {15'd0, 5'd5}, {48'd0, 16'h1234});
    chk("t1_early_en_a", 16'(en_a), 16'd0);
    idle();
    chk("t1_en_a", 16'(en_a), 16'd1);
    chk("t1_addr_a", 16'(addr_a), 16'd5);
    chk("t1_data_a", data_a, 16'h1234);
    chk("t1_en_b", 16'(en_b), 16'd0);
    idle();
    chk("t1_after_en_a", 16'(en_a), 16'd0);

    // all four sources at once
    do_reset();
    step(1'b0, 1'b0, 4'hF, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1},
         {16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0});
    idle();
    chk("t2_c1_addr_a", 16'(addr_a), 16'd1);
    chk("t2_c1_addr_b", 16'(addr_b), 16'd2);
    chk("t2_c1_en_b", 16'(en_b), 16'd1);
    idle();
    chk("t2_c2_addr_a", 16'(addr_a), 16'd3);
    chk("t2_c2_addr_b", 16'(addr_b), 16'd4);
    idle();
    chk("t2_c3_en_a", 16'(en_a), 16'd0);
    step(1'b0, 1'b0, 4'b0011, 4'b0011, {10'd0, 5'd11, 5'd10}, {32'd0, 16'h0B0B, 16'h0A0A});
    idle();
    chk("t2_rr_addr_a", 16'(addr_a), 16'd10);
    chk("t2_rr_addr_b", 16'(addr_b), 16'd11);

    // same destination from arithA and lsA
    do_reset();
    step(1'b0, 1'b0, 4'b0101, 4'b0101, {5'd0, 5'd7, 5'd0, 5'd7},
         {16'h0000, 16'hCCCC, 16'h0000, 16'hAAAA});
    idle();
    chk("t3_c1_data_a", data_a, 16'hAAAA);
    chk("t3_c1_en_b", 16'(en_b), 16'd0);
    idle();
    chk("t3_c2_en_a", 16'(en_a), 16'd1);
    chk("t3_c2_data_a", data_a, 16'hCCCC);
    chk("t3_c2_en_b", 16'(en_b), 16'd0);

    // sustained load, one register so only port A drains: stall then overflow
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, (i < 5) ? 4'hF : 4'h7, 4'hF, {4{5'd9}},
           {16'h3000 | 16'(i), 16'h2000 | 16'(i), 16'h1000 | 16'(i), 16'(i)});
      if (i == 2) chk("t4_stall_rise", 16'(stall), 16'd1);
    end
    chk("t4_stall", 16'(stall), 16'd1);
    chk("t4_ovf", 16'(overflow), 16'd1);
    repeat (16) idle();
    chk("t4_drained_stall", 16'(stall), 16'd0);
    chk("t4_ovf_sticky", 16'(overflow), 16'd1);

    // flush with buffered entries and new inputs
    do_reset();
    repeat (3) step(1'b0, 1'b0, 4'hF, 4'hF, {5'd23, 5'd22, 5'd21, 5'd20},
                    {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    step(1'b0, 1'b1, 4'hF, 4'hF, {5'd27, 5'd26, 5'd25, 5'd24},
         {16'h8888, 16'h7777, 16'h6666, 16'h5555});
    chk("t5_flush_en_a", 16'(en_a), 16'd0);
    chk("t5_flush_en_b", 16'(en_b), 16'd0);
    chk("t5_flush_stall", 16'(stall), 16'd0);
    idle();
    chk("t5_post_en_a", 16'(en_a), 16'd0);
    step(1'b0, 1'b0, 4'b0010, 4'b0010, {10'd0, 5'd12, 5'd0}, {32'd0, 16'h0C0C, 16'd0});
    idle();
    chk("t5_new_en_a", 16'(en_a), 16'd1);
    chk("t5_new_addr_a", 16'(addr_a), 16'd12);

    // valid without writeback request, then reset during drain
    do_reset();
    step(1'b0, 1'b0, 4'hF, 4'h0, {5'd1, 5'd2, 5'd3, 5'd4}, {4{16'hBEEF}});
    repeat (3) begin
      idle();
      chk("t6_nowb_en_a", 16'(en_a), 16'd0);
      chk("t6_nowb_en_b", 16'(en_b), 16'd0);
    end
    step(1'b0, 1'b0, 4'hF, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {4{16'h5A5A}});
    idle();
    chk("t6_drain_en_a", 16'(en_a), 16'd1);
    step(1'b1, 1'b0, 4'hF, 4'hF, {5'd8, 5'd7, 5'd6, 5'd5}, {4{16'h7E7E}});
    chk("t6_rst_en_a", 16'(en_a), 16'd0);
    chk("t6_rst_en_b", 16'(en_b), 16'd0);
    chk("t6_rst_addr_a", 16'(addr_a), 16'd0);
    chk("t6_rst_data_b", data_b, 16'd0);
    chk("t6_rst_stall", 16'(stall), 16'd0);
    idle();
    chk("t6_post_en_a", 16'(en_a), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
